// File: rtl/conv_window_if.sv
// Pixel-in / window-out stream bundle for the 3x3 window generator.
// Latency: none (wires only).
// Backpressure: pix_ready and win_ready form valid/ready handshakes on each side.
interface conv_window_if #(
  parameter int PIX_W = 4
);
  logic [PIX_W-1:0]   pix_in;
  logic               pix_valid;
  logic               pix_ready;
  logic [9*PIX_W-1:0] win_data;
  logic               win_valid;
  logic               win_ready;
  logic [2:0]         win_row;
  logic [2:0]         win_col;
  logic               win_last;

  // Producer/consumer side (drives pixels, accepts windows)
  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_data, win_valid, win_row, win_col, win_last
  );

  // Window generator side
  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_data, win_valid, win_row, win_col, win_last
  );
endinterface

// File: rtl/conv_window_gen.sv
// Builds 3x3 sliding windows from a raster pixel stream using two line buffers.
// Latency: window appears one cycle after accepting its bottom-right pixel.
// Backpressure: one-deep output register; pix_ready = !win_valid || win_ready.
module conv_window_gen #(
  parameter int IMG_W = 7,
  parameter int IMG_H = 7,
  parameter int K     = 3,
  parameter int PIX_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  conv_window_if.slave  bus
);

  typedef enum logic [0:0] {PRIME, ACTIVE} state_t;

  localparam logic [2:0] ROW_MAX = 3'(IMG_H - 1);
  localparam logic [2:0] COL_MAX = 3'(IMG_W - 1);

  state_t state, state_nxt;
  logic [2:0] row, col;

  // Line buffers: lb_r1 holds the row above the current one, lb_r2 the row above that.
  logic [PIX_W-1:0] lb_r1 [IMG_W];
  logic [PIX_W-1:0] lb_r2 [IMG_W];

  // 3x3 shift window; column K-1 is the most recently accepted column.
  logic [PIX_W-1:0] sw       [K][K];
  logic [PIX_W-1:0] win_next [K][K];
  logic [K*K*PIX_W-1:0] win_flat;

  logic acc, col_end, row_end, emit;

  assign bus.pix_ready = !bus.win_valid || bus.win_ready;
  assign acc     = bus.pix_valid && bus.pix_ready;
  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);
  // Only rows >= 2 (ACTIVE) and columns >= 2 complete a full window.
  assign emit    = acc && (state == ACTIVE) && (col >= 3'd2);

  // Raster position counters, advanced on accept and wrapping at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (acc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? 3'd0 : row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= PRIME;
    else     state <= state_nxt;
  end

  // FSM next state: ACTIVE once two full rows are buffered, back to PRIME at frame end.
  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   if (acc && row == 3'd1 && col_end) state_nxt = ACTIVE;
      ACTIVE:  if (acc && row_end && col_end)     state_nxt = PRIME;
      default: state_nxt = PRIME;
    endcase
  end

  // Next window: shift left by one column and append the new column from the line buffers.
  always_comb begin
    win_next = sw;
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_next[i][j] = sw[i][j+1];
      end
    end
    win_next[0][K-1] = lb_r2[col];
    win_next[1][K-1] = lb_r1[col];
    win_next[2][K-1] = bus.pix_in;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[PIX_W*(K*i+j) +: PIX_W] = win_next[i][j];
      end
    end
  end

  // Line buffers and shift window; no reset since stale data is overwritten before use.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb_r2[col] <= lb_r1[col];
      lb_r1[col] <= bus.pix_in;
      sw         <= win_next;
    end
  end

  // Output register: load on qualifying accept, otherwise drop valid once taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
      bus.win_data  <= '0;
    end else if (emit) begin
      bus.win_valid <= 1'b1;
      bus.win_last  <= row_end && col_end;
      bus.win_row   <= row - 3'd2;
      bus.win_col   <= col - 3'd2;
      bus.win_data  <= win_flat;
    end else if (bus.win_ready) begin
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: gap-free, stalled, random-gap, reset and back-to-back frames.
// Pixels are (7r+c+seed) mod 16 with a per-frame seed; frame seed 0 is the reference frame.
// Expected windows come from a behavioural model of the stream and output register.
module tb_conv_window_gen;

  typedef struct {
    logic [35:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        last;
    int          s;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_if #(.PIX_W(4)) bus ();

  conv_window_gen #(.IMG_W(7), .IMG_H(7), .K(3), .PIX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   mr = 0, mc = 0, seed = 0;
  int   acc_cnt = 0;
  int   ntaken = 0;
  bit   exp_vld = 1'b0;
  win_t q[$];

  function automatic logic [3:0] pixf(int s, int r, int c);
    return 4'(7 * r + c + s);
  endfunction

  function automatic win_t mkwin(int s, int r, int c);
    win_t w;
    w.d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.d[4*(3*i+j) +: 4] = pixf(s, r + i, c + j);
    w.r    = 3'(r);
    w.c    = 3'(c);
    w.last = (r == 4) && (c == 4);
    w.s    = s;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit pv, input bit wr);
    bit take, acc, qual;
    bus.pix_valid = pv;
    bus.win_ready = wr;
    bus.pix_in    = pv ? pixf(seed, mr, mc) : 4'($urandom);
    #1;
    chk("win_valid", 64'(bus.win_valid), 64'(exp_vld));
    chk("pix_ready", 64'(bus.pix_ready), 64'(!exp_vld || wr));
    take = exp_vld && wr;
    acc  = pv && (!exp_vld || wr);
    qual = 1'b0;
    if (exp_vld && q.size() > 0) begin
      chk("win_data", 64'(bus.win_data), 64'(q[0].d));
      chk("win_row",  64'(bus.win_row),  64'(q[0].r));
      chk("win_col",  64'(bus.win_col),  64'(q[0].c));
      chk("win_last", 64'(bus.win_last), 64'(q[0].last));
      if (take && q[0].s == 0 && (q[0].r == 0 && q[0].c == 0 || q[0].last))
        chk("hand_win", 64'(bus.win_data), 64'h0FE987210);
    end
    if (take) begin
      if (q.size() > 0) void'(q.pop_front());
      ntaken++;
    end
    if (acc) begin
      acc_cnt++;
      if (mr >= 2 && mc >= 2) begin
        qual = 1'b1;
        q.push_back(mkwin(seed, mr - 2, mc - 2));
      end
      if (mc == 6) begin
        mc = 0;
        if (mr == 6) begin
          mr = 0;
          seed = seed + 5;
        end else mr++;
      end else mc++;
    end
    exp_vld = qual ? 1'b1 : (take ? 1'b0 : exp_vld);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input int new_seed);
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      chk("rst_win_valid", 64'(bus.win_valid), 64'd0);
      chk("rst_win_last",  64'(bus.win_last),  64'd0);
      chk("rst_win_row",   64'(bus.win_row),   64'd0);
      chk("rst_win_col",   64'(bus.win_col),   64'd0);
      chk("rst_win_data",  64'(bus.win_data),  64'd0);
    end
    rst = 1'b0;
    mr = 0;
    mc = 0;
    seed = new_seed;
    q.delete();
    exp_vld = 1'b0;
  endtask

  // mode 0: gap-free; mode 1: win_ready low for 3 cycles mid-frame; mode 2: random gaps.
  task automatic run_pixels(input int npix, input int mode);
    int start;
    int budget;
    bit pv, wr;
    start  = acc_cnt;
    budget = 0;
    while (acc_cnt - start < npix && budget < 3000) begin
      pv = 1'b1;
      wr = 1'b1;
      if (mode == 1) wr = !(budget >= 20 && budget <= 22);
      if (mode == 2) begin
        pv = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
      end
      cycle(pv, wr);
      budget++;
    end
    chk("run_budget", 64'(budget < 3000), 64'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_vld && budget < 100) begin
      cycle(1'b0, 1'b1);
      budget++;
    end
    chk("drain_budget", 64'(budget < 100), 64'd1);
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b0;
    @(negedge clk);
    do_reset(2, 0);

    // Reference frame, gap-free, consumer always ready.
    ntaken = 0;
    run_pixels(49, 0);
    drain();
    chk("frame_count", 64'(ntaken), 64'd25);

    // Two back-to-back frames without reset.
    ntaken = 0;
    run_pixels(98, 0);
    drain();
    chk("b2b_count", 64'(ntaken), 64'd50);

    // Consumer stall of 3 cycles while a window is held.
    ntaken = 0;
    run_pixels(49, 1);
    drain();
    chk("stall_count", 64'(ntaken), 64'd25);

    // Random input gaps and random consumer readiness.
    ntaken = 0;
    run_pixels(49, 2);
    drain();
    chk("random_count", 64'(ntaken), 64'd25);

    // Reset after 20 accepted pixels, then a clean frame.
    run_pixels(20, 2);
    do_reset(2, 0);
    ntaken = 0;
    run_pixels(49, 0);
    drain();
    chk("post_rst_count", 64'(ntaken), 64'd25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, 7, image width in pixels.
REQ-002 SHALL have parameter IMG_H, 7, image height in pixels.
REQ-003 SHALL have parameter K, 3, window edge; only K=3 supported.
REQ-004 SHALL have parameter PIX_W, 4, pixel width in bits.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pix_in  input  PIX_W  raster-order pixel, row-major from (0,0).
REQ-008 SHALL have port pix_valid  input  1  pix_in valid.
REQ-009 SHALL have port pix_ready  output  1  pixel accepted when pix_valid&&pix_ready.
REQ-010 SHALL have port win_data  output  9*PIX_W  3x3 window; element k=3*i+j at bits [PIX_W*k+PIX_W-1 : PIX_W*k], i=row offset (0=top), j=col offset (0=left).
REQ-011 SHALL have port win_valid  output  1  win_data valid.
REQ-012 SHALL have port win_ready  input  1  consumer (multiply stage) takes window when win_valid&&win_ready.
REQ-013 SHALL have port win_row  output  3  top-left row of window, 0..IMG_H-3.
REQ-014 SHALL have port win_col  output  3  top-left column of window, 0..IMG_W-3.
REQ-015 SHALL have port win_last  output  1  high with the window at (IMG_H-3, IMG_W-3).

Function
REQ-016 SHALL keep input counters row (0..IMG_H-1) and col (0..IMG_W-1), advanced only on pixel accept; col wraps to 0 with row+1; after (IMG_H-1, IMG_W-1), both wrap to 0 (next frame).
REQ-017 SHALL store two previous image rows in line buffers of IMG_W entries each, plus a 3x3 shift window updated on each accept.
REQ-018 SHALL drive pix_ready = !win_valid || win_ready (one-deep output register, no bubble).
REQ-019 SHALL, on accepting pixel (r,c) with r>=2 and c>=2, load win_data with pixels (r-2..r, c-2..c), win_row=r-2, win_col=c-2, and set win_valid on the next cycle (latency 1).
REQ-020 SHALL NOT produce a window for accepts with r<2 or c<2; win_valid clears when the held window is taken and no new window is loaded that cycle.
REQ-021 SHALL, on simultaneous window take and qualifying accept, replace the window in the same cycle, keeping win_valid high.
REQ-022 SHALL hold win_data, win_row, win_col, win_last stable while win_valid&&!win_ready.
REQ-023 SHALL emit exactly (IMG_H-2)*(IMG_W-2)=25 windows per frame, in raster order of (win_row, win_col).
REQ-024 SHALL implement FSM states PRIME (row<2), ACTIVE (row>=2); PRIME->ACTIVE on accepting (1, IMG_W-1); ACTIVE->PRIME on accepting (IMG_H-1, IMG_W-1).
REQ-025 SHALL ignore pix_in when pix_valid is low; idle cycles change no state.

Reset
REQ-026 SHALL, while rst is high, set row=0, col=0, state=PRIME, win_valid=0, win_last=0, win_row=0, win_col=0, win_data=0, with pix_ready high from the first cycle after reset.
REQ-027 SHALL NOT clear line buffer contents on reset; they are overwritten before use.
REQ-028 SHALL, on reset mid-frame, discard the partial frame and treat the next accepted pixel as (0,0).

Verification
REQ-029 SHALL pass: pixel(r,c)=(7r+c) mod 16, pix_valid and win_ready always high -> first win_valid one cycle after accepting (2,2); window (0,0) elements k0..8 = 0,1,2,7,8,9,14,15,0.
REQ-030 SHALL pass: same frame -> exactly 25 windows, win_row/win_col sequence (0,0)..(4,4), win_last only on (4,4) with elements 0,1,2,7,8,9,14,15,0.
REQ-031 SHALL pass: win_ready low for 3 cycles with win_valid high -> win_data/win_row/win_col unchanged, pix_ready low, no pixel lost, window count remains 25.
REQ-032 SHALL pass: random pix_valid gaps (50%) and random win_ready -> windows identical to the gap-free run.
REQ-033 SHALL pass: rst asserted after 20 accepted pixels, then one full frame -> win_valid low during reset, next frame yields 25 correct windows starting at (0,0).
REQ-034 SHALL pass: two back-to-back frames without reset -> second frame's window (0,0) built only from second-frame pixels, 50 windows total.
